// File: rtl/posit_addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : posit_addsub_arbiter_if
//  Description : Requester, shared-datapath and result bundle for the
//                two-port posit add/sub arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface posit_addsub_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic         req0_sub;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic         req1_sub;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;

    logic [N-1:0] dp_a;
    logic [N-1:0] dp_b;
    logic [N-1:0] dp_result;

    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_id;
    logic [15:0]  op_count;

    // Environment side: requesters, add unit and result consumer.
    modport master (
        output req0_valid, req0_sub, req0_a, req0_b,
        output req1_valid, req1_sub, req1_a, req1_b,
        output dp_result, res_ready,
        input  req0_ready, req1_ready, dp_a, dp_b,
        input  res_valid, res_data, res_id, op_count
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_sub, req0_a, req0_b,
        input  req1_valid, req1_sub, req1_a, req1_b,
        input  dp_result, res_ready,
        output req0_ready, req1_ready, dp_a, dp_b,
        output res_valid, res_data, res_id, op_count
    );
endinterface
`default_nettype wire

// File: rtl/posit_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : posit_addsub_arbiter
//  Description : Round-robin arbiter feeding a shared combinational posit
//                adder through a two-stage issue/result pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_addsub_arbiter #(
    parameter int N  = 32,
    parameter int ES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    posit_addsub_arbiter_if.slave bus
);

    // ES only matters to the external adder; nothing here depends on it.
    if (ES >= N) begin : g_es_range
    end

    logic         r_s1_valid;
    logic         r_s1_id;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;
    logic         r_s2_valid;
    logic         r_s2_id;
    logic [N-1:0] r_s2_data;
    logic         r_rr_ptr;
    logic [15:0]  r_op_count;

    logic         w_s2_accept;
    logic         w_s1_advance;
    logic         w_s1_accept;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_ready0;
    logic         w_ready1;
    logic         w_hs;
    logic         w_res_fire;
    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;
    logic         w_sel_sub;
    logic [N-1:0] w_b_eff;

    assign w_s2_accept  = !r_s2_valid || bus.res_ready;
    assign w_s1_advance = r_s1_valid && w_s2_accept;
    assign w_s1_accept  = !r_s1_valid || w_s2_accept;
    assign w_res_fire   = r_s2_valid && bus.res_ready;

    // Sole requester wins outright; on contention rr_ptr picks.
    assign w_grant0 = bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
    assign w_grant1 = bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
    assign w_ready0 = w_grant0 && w_s1_accept;
    assign w_ready1 = w_grant1 && w_s1_accept;
    assign w_hs     = w_ready0 || w_ready1;

    assign w_sel_a   = w_ready1 ? bus.req1_a   : bus.req0_a;
    assign w_sel_b   = w_ready1 ? bus.req1_b   : bus.req0_b;
    assign w_sel_sub = w_ready1 ? bus.req1_sub : bus.req0_sub;
    // Posit negation is plain two's complement; zero and NaR are fixed points.
    assign w_b_eff   = w_sel_sub ? (~w_sel_b + {{(N-1){1'b0}}, 1'b1}) : w_sel_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_rr_ptr   <= 1'b0;
        end else if (w_hs) begin
            r_s1_valid <= 1'b1;
            r_rr_ptr   <= !w_ready1;
        end else if (w_s1_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_s1_id <= w_ready1;
            r_s1_a  <= w_sel_a;
            r_s1_b  <= w_b_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= 1'b1;
        end else if (w_res_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_advance) begin
            r_s2_id   <= r_s1_id;
            r_s2_data <= bus.dp_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_count <= 16'h0000;
        end else if (w_res_fire) begin
            r_op_count <= r_op_count + 16'h0001;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.dp_a       = r_s1_a;
    assign bus.dp_b       = r_s1_b;
    assign bus.res_valid  = r_s2_valid;
    assign bus.res_data   = r_s2_data;
    assign bus.res_id     = r_s2_id;
    assign bus.op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_posit_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_addsub_arbiter
//  Description : Randomized and directed bench with a queue-based reference
//                model of the arbiter, pipeline and completion counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_addsub_arbiter;

    localparam int c_N = 32;

    logic clk;
    logic reset;

    posit_addsub_arbiter_if #(.N(c_N)) bus ();

    posit_addsub_arbiter #(.N(c_N), .ES(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the shared posit adder: any same-cycle function will do.
    assign bus.dp_result = bus.dp_a + bus.dp_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b_eff;
        logic [31:0] data;
        int          age;
    } entry_t;

    entry_t      q[$];
    logic        last_id;
    logic [15:0] cnt;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare against the model, take the edge, update model.
    task automatic step(input logic v0, input logic v1, input logic s0, input logic s1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        logic   acc, g0, g1, fv;
        int     si;
        entry_t e;
        bus.req0_valid = v0; bus.req0_sub = s0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_sub = s1; bus.req1_a = a1; bus.req1_b = b1;
        bus.res_ready  = rr;
        #1;
        acc = (q.size() < 2) || rr;
        g0  = v0 && (!v1 || last_id == 1'b1);
        g1  = v1 && (!v0 || last_id == 1'b0);
        check("req0_ready", {31'b0, bus.req0_ready}, {31'b0, g0 && acc});
        check("req1_ready", {31'b0, bus.req1_ready}, {31'b0, g1 && acc});
        fv = (q.size() > 0) && (q[0].age >= 1);
        check("res_valid", {31'b0, bus.res_valid}, {31'b0, fv});
        if (fv) begin
            check("res_data", bus.res_data, q[0].data);
            check("res_id", {31'b0, bus.res_id}, {31'b0, q[0].id});
        end
        check("op_count", {16'b0, bus.op_count}, {16'b0, cnt});
        si = -1;
        if (q.size() == 2) si = 1;
        else if (q.size() == 1 && q[0].age == 0) si = 0;
        if (si >= 0) begin
            check("dp_a", bus.dp_a, q[si].a);
            check("dp_b", bus.dp_b, q[si].b_eff);
        end
        @(posedge clk);
        if (fv && rr) begin
            void'(q.pop_front());
            cnt++;
        end
        foreach (q[i]) q[i].age++;
        if ((g0 || g1) && acc) begin
            e.id    = g1;
            e.a     = g1 ? a1 : a0;
            e.b_eff = (g1 ? s1 : s0) ? (32'd0 - (g1 ? b1 : b0)) : (g1 ? b1 : b0);
            e.data  = e.a + e.b_eff;
            e.age   = 0;
            q.push_back(e);
            last_id = g1;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        last_id = 1'b1;
        cnt = 16'h0000;
        #1;
        check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
        check("rst_op_count", {16'b0, bus.op_count}, 32'd0);
    endtask

    task automatic rand_step(input logic rr);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom, rr);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        bus.req0_sub = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_sub = 0; bus.req1_a = 0; bus.req1_b = 0;
        do_reset();

        // Single uncontended add, then drain.
        step(1, 0, 0, 0, 32'h40000000, 32'h40000000, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("single_dp_b", bus.dp_b, 32'h40000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("single_res", bus.res_data, 32'h80000000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("single_cnt", {16'b0, bus.op_count}, 32'd1);

        // Negation corner cases on requester 1.
        step(0, 1, 0, 1, 0, 0, 32'h1, 32'h40000000, 1);
        check("neg_normal", bus.dp_b, 32'hC0000000);
        step(0, 1, 0, 1, 0, 0, 32'h2, 32'h80000000, 1);
        check("neg_nar", bus.dp_b, 32'h80000000);
        step(0, 1, 0, 1, 0, 0, 32'h3, 32'h00000000, 1);
        check("neg_zero", bus.dp_b, 32'h00000000);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Contention straight after reset: 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 1, 32'(i), 32'h10, 32'(i + 100), 32'h20, 1);
            check("rr_order", {31'b0, last_id}, 32'(i % 2));
        end
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: pipeline fills to two, then stalls.
        for (int i = 0; i < 5; i++) rand_step(0);
        check("bp_depth", 32'(q.size()), 32'd2);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 32'(i), 32'h5, 32'(i), 32'h7, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset with S1 and S2 full; req0 must win afterwards.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44, 0);
        check("mid_depth", 32'(q.size()), 32'd2);
        do_reset();
        step(1, 1, 0, 0, 32'h55, 32'h1, 32'h66, 32'h1, 1);
        check("mid_rr_winner", {31'b0, last_id}, 32'd0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++) rand_step($urandom_range(0, 3) != 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Counter wrap: stream one completion per cycle through 0xFFFF -> 0x0000.
        do_reset();
        for (int i = 0; i < 65537; i++) step(1, 1, 0, 0, 32'(i), 32'h1, 32'(i), 32'h2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("wrap_cnt", {16'b0, bus.op_count}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/posit_addsub_arbiter.md
POSIT_ADDSUB_ARBITER -- requirements
Module: posit_addsub_arbiter

Interface
REQ-001 Parameter N, default 32, posit word width.
REQ-002 Parameter ES, default 4, posit exponent field width; passed through to the shared datapath only.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 req0_valid / req1_valid  input  1  requester i has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester i operation accepted this cycle.
REQ-007 req0_sub / req1_sub  input  1  1 = a-b, 0 = a+b.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  N  posit operands.
REQ-009 dp_a, dp_b  output  N  operands to the shared combinational posit add unit.
REQ-010 dp_result  input  N  posit sum returned by the shared add unit, same cycle.
REQ-011 res_valid  output  1  result register holds a result.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 res_data  output  N  posit result.
REQ-014 res_id  output  1  requester index that owns res_data.
REQ-015 op_count  output  16  completed-operation counter.

Function
REQ-016 Two-stage pipeline: S1 issue register {s1_valid, s1_id, s1_a, s1_b}; S2 result register {s2_valid, s2_id, s2_data}.
REQ-017 dp_a = s1_a and dp_b = s1_b at all times.
REQ-018 Subtraction: the value latched into s1_b is the two's complement of req_b; add latches req_b unchanged.
REQ-019 Negation needs no special case: 0x00000000 maps to itself and NaR (0x80000000) maps to itself.
REQ-020 s2_accept = !s2_valid | res_ready.
REQ-021 s1_advance = s1_valid & s2_accept; on s1_advance, S2 loads s2_data=dp_result, s2_id=s1_id, s2_valid=1.
REQ-022 On s2_accept without s1_advance, s2_valid clears when res_valid & res_ready.
REQ-023 s1_accept = !s1_valid | s2_accept.
REQ-024 Round-robin arbiter with 1-bit pointer rr_ptr; rr_ptr names the priority requester.
REQ-025 grant_i: if only req_i_valid, grant i; if both valid, grant rr_ptr.
REQ-026 req_i_ready = grant_i & s1_accept, combinational; at most one ready per cycle.
REQ-027 On handshake from requester i: S1 loads the operands, s1_id=i, s1_valid=1, and rr_ptr becomes !i.
REQ-028 rr_ptr is unchanged when no handshake occurs.
REQ-029 If s1_advance occurs with no new handshake, s1_valid clears.
REQ-030 Latency: handshake at edge t gives res_valid high after edge t+1, with no backpressure.
REQ-031 Throughput: one operation per cycle while res_ready is held high.
REQ-032 Backpressure: while res_ready is low with S2 full, S2 and S1 hold, and req_ready is low if S1 is full.
REQ-033 No result is lost or duplicated under backpressure.
REQ-034 res_valid=s2_valid, res_data=s2_data, res_id=s2_id.
REQ-035 op_count increments by 1 on each res_valid & res_ready.
REQ-036 op_count wraps from 0xFFFF to 0x0000.
REQ-037 A requester may drop valid before ready; nothing is latched for it, and rr_ptr is unchanged unless the other requester handshakes.
REQ-038 Results return in acceptance order; res_id identifies the owner.

Reset
REQ-039 When reset is high at a rising edge: s1_valid=0, s2_valid=0, rr_ptr=0, op_count=0; data registers are don't-care.
REQ-040 Outputs during and immediately after reset: res_valid=0, req_ready follows REQ-026 with empty pipeline, dp_a/dp_b don't-care.
REQ-041 Reset asserted mid-operation discards all in-flight operations; no result for them is presented after reset.

Verification
REQ-042 Single op, no contention: req0 a=0x40000000, b=0x40000000, sub=0 -> req0_ready=1 at t; dp_a=dp_b=0x40000000 at t+1; res_valid=1 with res_data=dp_result and res_id=0 at t+2; op_count=1 after res handshake.
REQ-043 Subtract negation: req1 b=0x40000000, sub=1 -> dp_b=0xC0000000; b=0x80000000, sub=1 -> dp_b=0x80000000; b=0, sub=1 -> dp_b=0.
REQ-044 Contention after reset: both valid, held high for 4 cycles -> ready order 0,1,0,1; res_id sequence 0,1,0,1; one result per cycle.
REQ-045 Backpressure: res_ready=0 for 5 cycles with both requesters valid -> exactly two ops accepted (S1, S2 full), then all ready=0; when res_ready returns to 1, results emerge in order, none lost or duplicated.
REQ-046 Reset mid-flight: assert reset with S1 and S2 full -> next cycle res_valid=0, op_count=0, rr_ptr=0 (req0 wins the next contention).
REQ-047 Wrap: preload by 65535 completions, then one more -> op_count reads 0x0000.
